// File: rtl/fp16_accum.sv
// fp16_accum
//   Sequential FP16 accumulator. It sums a stream of FP16 products (one vector,
//   terminated by in_last) into a single FP16 result. Each element goes through
//   IDLE -> ALIGN -> ADD -> NORM, so the block takes one element every 4 cycles.
//   Arithmetic truncates, flushes denormals to zero, clamps inf/NaN operands to
//   the largest finite value and saturates overflow.
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     element handshake; in_data FP16, in_last ends vector
//   out_valid/out_ready   result handshake; out_data FP16 sum,
//                         out_count elements summed (saturating, CNT_W bits)
module fp16_accum #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ALIGN = 3'd1;
  localparam logic [2:0] S_ADD   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [15:0]      r_acc;
  logic [CNT_W-1:0] r_count;
  logic [15:0]      r_din;
  logic             r_last;
  // aligned operands / sum carried between stages
  logic             r_sgn;
  logic             r_sub;
  logic [4:0]       r_exp;
  logic [10:0]      r_mbig;
  logic [10:0]      r_msml;
  logic [11:0]      r_sum;

  // Clean an operand into {sign, exp, 11-bit mantissa with hidden one}.
  // Zeros/denormals become exp=0, man=0 so they never win the magnitude compare
  // against a real number and contribute nothing when shifted.
  function automatic logic [16:0] clean(input logic [15:0] v);
    if (v[14:10] == 5'd0)
      clean = 17'd0;
    else if (v[14:10] == 5'd31)
      clean = {v[15], 5'd30, 11'h7FF};
    else
      clean = {v[15], v[14:10], 1'b1, v[9:0]};
  endfunction

  // ---------------- ALIGN ----------------
  logic [16:0] w_a, w_b, w_big, w_sml;
  logic [4:0]  w_diff;
  logic [10:0] w_shf;

  always_comb begin
    w_a = clean(r_acc);
    w_b = clean(r_din);
    if (w_a[15:0] >= w_b[15:0]) begin
      w_big = w_a;
      w_sml = w_b;
    end else begin
      w_big = w_b;
      w_sml = w_a;
    end
    w_diff = w_big[15:11] - w_sml[15:11];
    w_shf  = (w_diff >= 5'd11) ? 11'd0 : (w_sml[10:0] >> w_diff);
  end

  // ---------------- NORM ----------------
  logic [3:0]        w_lz;
  logic [10:0]       w_mn;
  logic signed [6:0] w_exp_n;
  logic [15:0]       w_res;

  always_comb begin
    w_lz = 4'd0;
    for (int i = 0; i < 11; i++)
      if (r_sum[i]) w_lz = 4'(10 - i);   // highest set bit wins
    if (r_sum[11]) begin
      w_mn    = r_sum[11:1];
      w_exp_n = $signed({2'b00, r_exp}) + 7'sd1;
    end else begin
      w_mn    = r_sum[10:0] << w_lz;
      w_exp_n = $signed({2'b00, r_exp}) - $signed({3'b000, w_lz});
    end
    if (r_sum == 12'd0 || w_exp_n <= 7'sd0)
      w_res = 16'h0000;
    else if (w_exp_n >= 7'sd31)
      w_res = {r_sgn, 15'h7BFF};
    else
      w_res = {r_sgn, w_exp_n[4:0], w_mn[9:0]};
  end

  // ---------------- control + datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= 16'h0000;
      r_count <= '0;
      r_din   <= 16'h0000;
      r_last  <= 1'b0;
      r_sgn   <= 1'b0;
      r_sub   <= 1'b0;
      r_exp   <= 5'd0;
      r_mbig  <= 11'd0;
      r_msml  <= 11'd0;
      r_sum   <= 12'd0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_din   <= in_data;
          r_last  <= in_last;
          if (r_count != '1) r_count <= r_count + 1'b1;
          r_state <= S_ALIGN;
        end
        S_ALIGN: begin
          r_sgn   <= w_big[16];
          r_sub   <= w_big[16] ^ w_sml[16];
          r_exp   <= w_big[15:11];
          r_mbig  <= w_big[10:0];
          r_msml  <= w_shf;
          r_state <= S_ADD;
        end
        S_ADD: begin
          r_sum   <= r_sub ? ({1'b0, r_mbig} - {1'b0, r_msml})
                           : ({1'b0, r_mbig} + {1'b0, r_msml});
          r_state <= S_NORM;
        end
        S_NORM: begin
          r_acc   <= w_res;
          r_state <= r_last ? S_DONE : S_IDLE;
        end
        S_DONE: if (out_ready) begin
          r_acc   <= 16'h0000;
          r_count <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_data  = r_acc;
  assign out_count = r_count;

endmodule

// File: tb/tb_fp16_accum.sv
module tb_fp16_accum;
  localparam int CNT_W = 4;              // small so saturation is cheap to reach
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [15:0]      in_data = 16'h0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;

  fp16_accum #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: value-level FP16 add. Each operand is an integer mantissa scaled
  // by 2^(e-25); both are brought to the grid of the larger exponent with floor
  // truncation, summed as signed integers, then renormalized into [1024,2048).
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, e, s, mag;
    logic sg;
    logic [15:0] r;
    ea = a[14:10]; ma = 1024 + a[9:0];
    eb = b[14:10]; mb = 1024 + b[9:0];
    if (ea == 0) ma = 0; else if (ea == 31) begin ea = 30; ma = 2047; end
    if (eb == 0) mb = 0; else if (eb == 31) begin eb = 30; mb = 2047; end
    e = (ea > eb) ? ea : eb;
    ma = ma >> (e - ea);
    mb = mb >> (e - eb);
    s = (a[15] ? -ma : ma) + (b[15] ? -mb : mb);
    if (s == 0) return 16'h0000;
    sg = (s < 0);
    mag = sg ? -s : s;
    while (mag >= 2048) begin mag = mag >> 1; e++; end
    while (mag < 1024) begin mag = mag << 1; e--; end
    if (e <= 0) return 16'h0000;
    if (e >= 31) return {sg, 15'h7BFF};
    r = {sg, 5'(e), 10'(mag)};
    return r;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 9))
      0:       return 16'($urandom);
      1:       return {1'($urandom), ($urandom_range(0, 1) != 0) ? 5'd31 : 5'd0, 10'($urandom)};
      default: return {1'($urandom), 5'($urandom_range(12, 18)), 10'($urandom)};
    endcase
  endfunction

  // Present one element, wait (bounded) for acceptance, then check the
  // handshake timing: 3 cycles of in_ready low, or out_valid in cycle t+4.
  task automatic send(input logic [15:0] d, input logic last);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = rnd16(); in_last = 1'($urandom);
    n = 0;
    if (!last) begin
      forever begin
        @(negedge clk);
        if (in_ready || n >= 10) break;
        n++;
      end
      chk("in_ready_low_cycles", n, 3);
    end else begin
      do begin @(negedge clk); n++; end while (!out_valid && n < 10);
      chk("out_valid_latency", n, 4);
    end
  endtask

  task automatic recv(input logic [15:0] ed, input int ec, input int hold);
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    chk("out_data", {16'd0, out_data}, {16'd0, ed});
    chk("out_count", {28'd0, out_count}, ec);
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'($urandom) & 1'b0;
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_data", {16'd0, out_data}, {16'd0, ed});
      chk("hold_count", {28'd0, out_count}, ec);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("post_valid", {31'd0, out_valid}, 32'd0);
    chk("post_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_count", {28'd0, out_count}, 32'd0);
  endtask

  task automatic run_vec(input logic [15:0] v[$], input int hold);
    logic [15:0] acc;
    acc = 16'h0000;
    foreach (v[i]) begin
      acc = ref_add(acc, v[i]);
      send(v[i], i == v.size() - 1);
    end
    recv(acc, (v.size() > CMAX) ? CMAX : v.size(), hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v[$];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_count", {28'd0, out_count}, 32'd0);

    // directed vectors from hand-worked sums
    v = '{16'h3C00};                 run_vec(v, 0); // T1
    v = '{16'h3C00, 16'h4000, 16'h4200}; run_vec(v, 1); // 1+2+3 = 6
    v = '{16'h3C00, 16'hBC00};       run_vec(v, 0);
    v = '{16'h6400, 16'h3C00};       run_vec(v, 0);
    v = '{16'h6800, 16'h3C00};       run_vec(v, 0);
    v = '{16'h7BFF, 16'h7BFF};       run_vec(v, 0);
    v = '{16'hFC00, 16'h3C00};       run_vec(v, 0);
    v = '{16'h0001, 16'h3C00};       run_vec(v, 0);
    v = '{16'h8000};                 run_vec(v, 0); // -0 -> +0
    chk("lit_6", {16'd0, ref_add(ref_add(16'h3C00, 16'h4000), 16'h4200)}, 32'h4600);

    // T5: long back-pressure, then a fresh vector must start from zero
    v = '{16'h3C00};                 run_vec(v, 5);
    v = '{16'h4000};                 run_vec(v, 0);

    // T6: reset in the middle of a vector
    send(16'h3C00, 1'b0);
    send(16'h4000, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h4200; in_last = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_data", {16'd0, out_data}, 32'd0);
    chk("midrst_out_count", {28'd0, out_count}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{16'h4000};                 run_vec(v, 0);

    // count saturation
    v = {};
    for (int i = 0; i < CMAX + 3; i++) v.push_back(16'h3C00 | 16'($urandom_range(0, 255)));
    run_vec(v, 0);

    // randomized vectors
    for (int t = 0; t < 40; t++) begin
      v = {};
      for (int i = 0; i < $urandom_range(1, 5); i++) v.push_back(rnd16());
      run_vec(v, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
